tl_tick_ped_req: RTL



---
 rtl/tl_pkg.sv | 22 ++
 rtl/tl_debounce.sv | 47 ++++
 rtl/tl_tick_ped_req.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and default constants for the traffic-light timing/request stage.
package tl_pkg;

    // Pedestrian request FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } tl_req_state_e;

    localparam int unsigned PHASE_W          = 4;
    localparam int unsigned CLK_DIV_DEF      = 50000000;
    localparam int unsigned DEB_CYCLES_DEF   = 20;
    localparam int unsigned LOCKOUT_SECS_DEF = 5;
    localparam int unsigned COUNT_MOD_DEF    = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for the pedestrian button.
// btn_db follows the synchronized level only after DEB_CYCLES consecutive
// samples disagree with the current debounced level.
module tl_debounce
    import tl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_db
);

    localparam int unsigned DEB_W = cnt_w(DEB_CYCLES);

    logic             sync_q1;
    logic             sync_q2;
    logic [DEB_W-1:0] deb_cnt;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt <= '0;
            btn_db  <= 1'b0;
        end else if (sync_q2 == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            btn_db  <= sync_q2;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

endmodule

// File: rtl/tl_tick_ped_req.sv
// Timing and pedestrian-request stage for the three-way traffic light.
// Produces a one-cycle seconds tick, a wrapping phase count, and a held
// pedestrian request that clears on controller acknowledge followed by a
// lockout of LOCKOUT_SECS ticks.
// Optional feature: define TL_PED_CHIRP_EN to add the ped_chirp output,
// which toggles once per second while a request is pending.
module tl_tick_ped_req
    import tl_pkg::*;
#(
    parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int unsigned LOCKOUT_SECS = LOCKOUT_SECS_DEF,
    parameter int unsigned COUNT_MOD    = COUNT_MOD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ped_btn,
    input  logic               ped_ack,
    output logic               sec_tick,
    output logic [PHASE_W-1:0] phase_cnt,
    output logic               ped_req,
    output logic               ped_busy,
    output logic               btn_db
`ifdef TL_PED_CHIRP_EN
    ,
    output logic               ped_chirp
`endif
);

    localparam int unsigned DIV_W  = cnt_w(CLK_DIV);
    localparam int unsigned LOCK_W = cnt_w(LOCKOUT_SECS + 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              div_wrap_c;
    logic              btn_db_q;
    logic              press_c;
    tl_req_state_e     state;
    tl_req_state_e     state_d;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_cnt_d;

    // Debounced button level
    tl_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (ped_btn),
        .btn_db (btn_db)
    );

    assign div_wrap_c = (div_cnt == DIV_W'(CLK_DIV - 1));

    // Prescaler: sec_tick is high the cycle after the divider reaches its top
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            sec_tick <= 1'b0;
        end else begin
            div_cnt  <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
            sec_tick <= div_wrap_c;
        end
    end

    // Phase count advances together with sec_tick and wraps at COUNT_MOD
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if (div_wrap_c) begin
            if (phase_cnt == PHASE_W'(COUNT_MOD - 1)) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PHASE_W'(1);
            end
        end
    end

    // Delayed debounced level for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
        end
    end

    assign press_c = btn_db & ~btn_db_q;

    // Request FSM next-state; ack outranks a coincident press in PENDING
    always_comb begin
        state_d    = state;
        lock_cnt_d = lock_cnt;
        case (state)
            IDLE: begin
                if (press_c) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (ped_ack) begin
                    state_d    = LOCKOUT;
                    lock_cnt_d = LOCK_W'(LOCKOUT_SECS);
                end
            end
            LOCKOUT: begin
                if (sec_tick) begin
                    if (lock_cnt == LOCK_W'(1)) begin
                        state_d    = IDLE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt - LOCK_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Request FSM state register with registered status decode
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
            ped_req  <= 1'b0;
            ped_busy <= 1'b0;
        end else begin
            state    <= state_d;
            lock_cnt <= lock_cnt_d;
            ped_req  <= (state_d == PENDING);
            ped_busy <= (state_d == LOCKOUT);
        end
    end

`ifdef TL_PED_CHIRP_EN
    logic chirp_d;

    // Chirp toggles per tick while pending and drops as soon as PENDING is left
    always_comb begin
        chirp_d = 1'b0;
        if (state_d == PENDING) begin
            chirp_d = ped_chirp;
            if ((state == PENDING) && sec_tick) begin
                chirp_d = ~ped_chirp;
            end
        end
    end

    // Chirp output register
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_chirp <= 1'b0;
        end else begin
            ped_chirp <= chirp_d;
        end
    end
`endif

endmodule
